serial_parity_checker: RTL

Receive-side stage for the parity generator. It accepts a serial frame of DATA_W data bits followed by one parity bit, rebuilds the data word, recomputes parity in even or odd mode, and reports the word with a parity-error flag. It also keeps a saturating count of parity errors for status readout.

---
 rtl/parity_pkg.sv | 13 +
 rtl/sat_counter.sv | 22 ++
 rtl/serial_parity_checker.sv | 110 +++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity receive path.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_W data bits LSB first plus one parity bit,
// reports the rebuilt word, a parity-error flag and a saturating error count.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              bit_valid_i,
  input  logic              bit_i,
  input  logic              odd_mode_i,
  input  logic              clr_cnt_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              par_err_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              par;
  logic              odd_q;
  logic              cnt_inc;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start_i) state_n = DATA;
      end
      DATA: begin
        if (start_i) state_n = DATA;
        else if (bit_valid_i && (bit_cnt == CW'(DATA_W - 1))) state_n = PARITY;
      end
      PARITY: begin
        if (start_i) state_n = DATA;
        else if (bit_valid_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // busy_o is registered from the next-state value so it lines up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      odd_q     <= PAR_EVEN;
      data_o    <= '0;
      valid_o   <= 1'b0;
      par_err_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      busy_o  <= (state_n != IDLE);
      if (start_i) begin
        odd_q   <= odd_mode_i;
        bit_cnt <= '0;
        par     <= 1'b0;
        shreg   <= '0;
      end else if (bit_valid_i) begin
        unique case (state)
          DATA: begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if (bit_cnt == CW'(i)) shreg[i] <= bit_i;
            end
            par     <= par ^ bit_i;
            bit_cnt <= bit_cnt + CW'(1);
          end
          PARITY: begin
            valid_o   <= 1'b1;
            data_o    <= shreg;
            par_err_o <= bit_i ^ par ^ odd_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign cnt_inc = valid_o & par_err_o;

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (clr_cnt_i),
    .count (err_cnt_o)
  );

endmodule
